// File: rtl/majority_voter_seq.sv
// Majority voter over N redundant channel words.
// Each accepted word set is voted bit by bit over the channels that are
// still active. A channel that disagrees with the vote on FAULT_LIMIT
// consecutive transfers is excluded until clear_faults. Output is a
// one-deep valid/ready register stage.
//
// state | meaning
// ------+---------------------------------------------
// 0     | NORMAL   - no channel excluded
// 1     | DEGRADED - some channel excluded, two or more still active
// 2     | FAILED   - fewer than two channels active
module majority_voter_seq #(
  parameter int N           = 3,
  parameter int W           = 8,
  parameter int FAULT_LIMIT = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic [N*W-1:0] in_data,
  output logic           in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  input  logic           out_ready,
  input  logic           clear_faults,
  output logic [N-1:0]   mismatch,
  output logic [N-1:0]   fault,
  output logic [1:0]     state
);

  typedef enum logic [1:0] {
    ST_NORMAL   = 2'd0,
    ST_DEGRADED = 2'd1,
    ST_FAILED   = 2'd2
  } state_t;

  localparam logic [3:0] LIMIT = 4'(FAULT_LIMIT);

  logic               r_out_valid;
  logic [W-1:0]       r_out_data;
  logic [N-1:0]       r_mismatch;
  logic [N-1:0]       r_fault;
  logic [N-1:0][3:0]  r_cnt;

  logic               w_xfer;
  logic [3:0]         w_act_cnt;
  logic [W-1:0]       w_tie_word;
  logic [W-1:0]       w_vote;
  logic [N-1:0]       w_mis;
  logic [N-1:0]       w_cand;
  logic [N-1:0]       w_fault_try;
  logic [N-1:0]       w_fault_next;
  logic [N-1:0][3:0]  w_cnt_next;
  state_t             w_state;

  assign in_ready = !r_out_valid || out_ready;
  assign w_xfer   = in_valid && in_ready;

  // Count active channels; the downward scan leaves the lowest active word as tie-breaker.
  always_comb begin
    w_act_cnt  = '0;
    w_tie_word = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!r_fault[i]) begin
        w_act_cnt  = w_act_cnt + 4'd1;
        w_tie_word = in_data[i*W +: W];
      end
    end
  end

  // Per-bit vote: strict majority wins, exact tie follows the lowest active channel.
  // One active channel passes straight through; none gives zero.
  always_comb begin : p_vote
    logic [3:0] ones;
    w_vote = '0;
    ones   = '0;
    for (int b = 0; b < W; b++) begin
      ones = '0;
      for (int i = 0; i < N; i++) begin
        if (!r_fault[i] && in_data[i*W+b]) ones = ones + 4'd1;
      end
      if ({ones, 1'b0} > {1'b0, w_act_cnt})
        w_vote[b] = 1'b1;
      else if (({ones, 1'b0} == {1'b0, w_act_cnt}) && (w_act_cnt != 4'd0))
        w_vote[b] = w_tie_word[b];
    end
  end

  // Mismatch flags, saturating disagreement counters and candidate exclusions.
  // Exclusions are dropped as a group if they would leave no channel active.
  always_comb begin
    w_mis      = '0;
    w_cand     = '0;
    w_cnt_next = r_cnt;
    for (int i = 0; i < N; i++) begin
      if (!r_fault[i]) begin
        w_mis[i] = (in_data[i*W +: W] != w_vote);
        if (w_mis[i]) begin
          w_cnt_next[i] = (r_cnt[i] == 4'hF) ? 4'hF : r_cnt[i] + 4'd1;
          w_cand[i]     = (w_cnt_next[i] >= LIMIT);
        end else begin
          w_cnt_next[i] = '0;
        end
      end
    end
    w_fault_try  = r_fault | w_cand;
    w_fault_next = (&w_fault_try) ? r_fault : w_fault_try;
  end

  // Health summary derived from the registered exclusion mask.
  always_comb begin
    w_state = ST_NORMAL;
    if (r_fault != '0)
      w_state = (w_act_cnt >= 4'd2) ? ST_DEGRADED : ST_FAILED;
  end

  // Output stage: load on transfer, drop valid once consumed with nothing new.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_mismatch  <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_vote;
      r_mismatch  <= w_mis;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Fault bookkeeping: clear_faults overrides any update from a same-cycle transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fault <= '0;
      r_cnt   <= '0;
    end else if (clear_faults) begin
      r_fault <= '0;
      r_cnt   <= '0;
    end else if (w_xfer) begin
      r_fault <= w_fault_next;
      r_cnt   <= w_cnt_next;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign mismatch  = r_mismatch;
  assign fault     = r_fault;
  assign state     = w_state;

endmodule

// File: tb/tb_majority_voter_seq.sv
// Bench for majority_voter_seq (N=3, W=8, FAULT_LIMIT=4): directed scenarios
// followed by random traffic, checked against a word-level reference model
// and an output scoreboard.
module tb_majority_voter_seq;

  localparam int N   = 3;
  localparam int W   = 8;
  localparam int LIM = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic [N*W-1:0] in_data;
  logic           in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_ready;
  logic           clear_faults;
  logic [N-1:0]   mismatch;
  logic [N-1:0]   fault;
  logic [1:0]     state;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic               m_ov;
  logic [N-1:0]       m_fault;
  logic [N-1:0]       m_mis;
  int                 m_cnt [N];
  logic [W+N-1:0]     sb_q [$];

  majority_voter_seq #(.N(N), .W(W), .FAULT_LIMIT(LIM)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .clear_faults (clear_faults),
    .mismatch     (mismatch),
    .fault        (fault),
    .state        (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] m_state();
    int act = 0;
    for (int i = 0; i < N; i++) if (!m_fault[i]) act++;
    if (m_fault == '0) return 2'd0;
    if (act >= 2) return 2'd1;
    return 2'd2;
  endfunction

  task automatic model_reset();
    m_ov    = 1'b0;
    m_fault = '0;
    m_mis   = '0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    sb_q.delete();
  endtask

  // One clock of the specification's behaviour, evaluated on the inputs
  // that the DUT will see at the coming rising edge.
  task automatic model_step(input logic v, input logic [N*W-1:0] d,
                            input logic ordy, input logic clr);
    logic [W-1:0] words [N];
    logic [W-1:0] vote;
    logic [N-1:0] mis, newf;
    int act, ones, first;
    for (int i = 0; i < N; i++) words[i] = d[i*W +: W];
    if (v && (!m_ov || ordy)) begin
      act = 0;
      first = -1;
      for (int i = 0; i < N; i++)
        if (!m_fault[i]) begin
          act++;
          if (first < 0) first = i;
        end
      vote = '0;
      if (act == 1) vote = words[first];
      else if (act > 1)
        for (int b = 0; b < W; b++) begin
          ones = 0;
          for (int i = 0; i < N; i++) if (!m_fault[i] && words[i][b]) ones++;
          if (2 * ones > act) vote[b] = 1'b1;
          else if (2 * ones == act) vote[b] = words[first][b];
        end
      mis = '0;
      for (int i = 0; i < N; i++) mis[i] = !m_fault[i] && (words[i] != vote);
      sb_q.push_back({vote, mis});
      m_mis = mis;
      m_ov  = 1'b1;
      if (!clr) begin
        newf = m_fault;
        for (int i = 0; i < N; i++)
          if (!m_fault[i]) begin
            if (mis[i]) begin
              m_cnt[i] = (m_cnt[i] < 15) ? m_cnt[i] + 1 : 15;
              if (m_cnt[i] >= LIM) newf[i] = 1'b1;
            end else begin
              m_cnt[i] = 0;
            end
          end
        if (newf != {N{1'b1}}) m_fault = newf;
      end
    end else if (ordy) begin
      m_ov = 1'b0;
    end
    if (clr) begin
      m_fault = '0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end
  endtask

  task automatic check_state();
    chk("in_ready",  32'(in_ready),  32'(!m_ov || out_ready));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("fault",     32'(fault),     32'(m_fault));
    chk("state",     32'(state),     32'(m_state()));
    chk("mismatch",  32'(mismatch),  32'(m_mis));
  endtask

  // Drive one cycle of inputs, check and advance the model away from the edge.
  task automatic step(input logic v, input logic [N*W-1:0] d,
                      input logic ordy, input logic clr);
    in_valid     = v;
    in_data      = d;
    out_ready    = ordy;
    clear_faults = clr;
    @(negedge clk);
    check_state();
    model_step(v, d, ordy, clr);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every output consumed downstream is compared with the oldest expectation.
  initial begin : monitor
    logic [W+N-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_empty: got output %0h expected none", out_data);
        end else begin
          e = sb_q.pop_front();
          chk("sb_data",     32'(out_data), 32'(e[W+N-1:N]));
          chk("sb_mismatch", 32'(mismatch), 32'(e[N-1:0]));
        end
      end
    end
  end

  initial begin : stim
    logic [N*W-1:0] d;
    logic [W-1:0]   base;
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    in_data      = '0;
    out_ready    = 1'b0;
    clear_faults = 1'b0;
    model_reset();
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_fault",     32'(fault),     32'd0);
    chk("rst_state",     32'(state),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // basic vote, then channel 2 disagrees four times in a row
    step(1'b1, {8'hA5, 8'h5A, 8'h5A}, 1'b1, 1'b0);
    chk("v1_out_valid", 32'(out_valid), 32'd1);
    chk("v1_out_data",  32'(out_data),  32'h5A);
    chk("v1_mismatch",  32'(mismatch),  32'b100);
    chk("v1_state",     32'(state),     32'd0);
    for (int k = 0; k < 3; k++) step(1'b1, {8'hA5, 8'h5A, 8'h5A}, 1'b1, 1'b0);
    chk("f2_fault", 32'(fault), 32'b100);
    chk("f2_state", 32'(state), 32'd1);
    step(1'b1, {8'hFF, 8'hF0, 8'h0F}, 1'b1, 1'b0);
    chk("tie_out_data", 32'(out_data), 32'h0F);

    // backpressure holds the output word
    step(1'b1, {8'h77, 8'h77, 8'h77}, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, {8'h11, 8'h11, 8'h11}, 1'b0, 1'b0);
      chk("hold_in_ready", 32'(in_ready),  32'd0);
      chk("hold_out_data", 32'(out_data),  32'h77);
      chk("hold_valid",    32'(out_valid), 32'd1);
    end
    in_valid  = 1'b1;
    in_data   = {8'h66, 8'h66, 8'h66};
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", 32'(in_ready), 32'd1);
    step(1'b1, {8'h66, 8'h66, 8'h66}, 1'b1, 1'b0);
    chk("release_out_data", 32'(out_data), 32'h66);

    // clear coincident with a transfer votes with the old mask
    step(1'b1, {8'h33, 8'h22, 8'h11}, 1'b1, 1'b1);
    chk("clr_out_data", 32'(out_data), 32'h11);
    chk("clr_mismatch", 32'(mismatch), 32'b010);
    chk("clr_fault",    32'(fault),    32'd0);
    chk("clr_state",    32'(state),    32'd0);

    // fault channel 1, hold an output, then pulse reset between edges
    for (int k = 0; k < 4; k++) step(1'b1, {8'hAA, 8'h55, 8'hAA}, 1'b1, 1'b0);
    chk("f1_fault", 32'(fault), 32'b010);
    step(1'b1, {8'h11, 8'h11, 8'h11}, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_out_valid", 32'(out_valid), 32'd0);
    chk("ar_out_data",  32'(out_data),  32'd0);
    chk("ar_mismatch",  32'(mismatch),  32'd0);
    chk("ar_fault",     32'(fault),     32'd0);
    chk("ar_state",     32'(state),     32'd0);
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // first transfer after reset sees every channel; then fault 1 and 2
    step(1'b1, {8'hAA, 8'h55, 8'hAA}, 1'b1, 1'b0);
    chk("pr_out_data", 32'(out_data), 32'hAA);
    chk("pr_mismatch", 32'(mismatch), 32'b010);
    for (int k = 0; k < 3; k++) step(1'b1, {8'hAA, 8'h55, 8'hAA}, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b1, {8'h11, 8'h00, 8'h33}, 1'b1, 1'b0);
    chk("ff_fault", 32'(fault), 32'b110);
    chk("ff_state", 32'(state), 32'd2);
    step(1'b1, {8'h3C, 8'h77, 8'hC3}, 1'b1, 1'b0);
    chk("ff_out_data", 32'(out_data), 32'hC3);
    for (int k = 0; k < 10; k++) begin
      d = 24'($urandom);
      step(1'b1, d, 1'b1, 1'b0);
    end
    chk("last_fault", 32'(fault), 32'b110);
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("clr2_fault", 32'(fault), 32'd0);

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      base = W'($urandom);
      for (int i = 0; i < N; i++)
        d[i*W +: W] = ($urandom_range(0, 3) == 0) ? W'($urandom) : base;
      step($urandom_range(0, 9) < 7, d, $urandom_range(0, 9) < 7,
           $urandom_range(0, 99) == 0);
    end

    for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b1, 1'b0);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
